// File: rtl/brm_sync_ctrl_if.sv
// SD sector handshake and BRM port-B bus shared between brm_sync_ctrl (master) and hps_io/BRM (slave).
// Latency: none (signal bundle only); backpressure is the sd_ack pulse handshake.
interface brm_sync_ctrl_if #(
   parameter int AW = 12
);
   logic [31:0]   sd_lba;
   logic          sd_rd;
   logic          sd_wr;
   logic          sd_ack;
   logic [7:0]    sd_buff_addr;
   logic [15:0]   sd_buff_dout;
   logic          sd_buff_wr;
   logic [AW-1:0] bram_addr;
   logic [15:0]   bram_din;
   logic          bram_we;

   modport master (
      output sd_lba, sd_rd, sd_wr, bram_addr, bram_din, bram_we,
      input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
   );

   modport slave (
      input  sd_lba, sd_rd, sd_wr, bram_addr, bram_din, bram_we,
      output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
   );
endinterface

// File: rtl/brm_sync_ctrl.sv
// BRM port-B sequencer: multi-sector SD load/save of a save slot and HuBM format; busy 2 cycles after a request edge.
// Backpressure: each sector waits for an sd_ack pulse; BRM_FORMAT_CLEAR_EN makes format zero the whole BRM.
module brm_sync_ctrl #(
   parameter int SECTORS = 16,
   parameter int AW      = $clog2(SECTORS) + 8
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       downloading,
   input  logic       img_mounted,
   input  logic       img_readonly,
   input  logic       img_size_nz,
   input  logic       load_req,
   input  logic       save_req,
   input  logic       format_req,
   input  logic [1:0] slot,
   brm_sync_ctrl_if.master bus,
   output logic       enabled,
   output logic       busy,
   output logic       loading
);
   localparam int LB = $clog2(SECTORS);
`ifdef BRM_FORMAT_CLEAR_EN
   localparam logic [AW-1:0] FMT_LAST = AW'(SECTORS * 256 - 1);
`else
   localparam logic [AW-1:0] FMT_LAST = AW'(3);
`endif

   typedef enum logic [1:0] {IDLE, XFER, FMT} state_t;

   state_t        state, state_nxt;
   logic [31:0]   lba, lba_nxt;
   logic          rd, rd_nxt, wr, wr_nxt, ld, ld_nxt;
   logic [AW-1:0] cnt, cnt_nxt;
   logic          dl_q, ack_q, load_q, save_q, fmt_q;
   logic          go_load, go_save, go_fmt;
   logic          load_edge, save_edge, fmt_edge, idle_free;

   assign load_edge = load_req & ~load_q;
   assign save_edge = save_req & ~save_q;
   assign fmt_edge  = format_req & ~fmt_q;
   // A start strobe already in flight counts as busy so a second edge cannot sneak in.
   assign idle_free = (state == IDLE) & ~(go_load | go_save | go_fmt);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state   <= IDLE;
         lba     <= '0;
         rd      <= 1'b0;
         wr      <= 1'b0;
         ld      <= 1'b0;
         cnt     <= '0;
         dl_q    <= 1'b0;
         ack_q   <= 1'b0;
         load_q  <= 1'b0;
         save_q  <= 1'b0;
         fmt_q   <= 1'b0;
         go_load <= 1'b0;
         go_save <= 1'b0;
         go_fmt  <= 1'b0;
         enabled <= 1'b0;
      end else begin
         state   <= state_nxt;
         lba     <= lba_nxt;
         rd      <= rd_nxt;
         wr      <= wr_nxt;
         ld      <= ld_nxt;
         cnt     <= cnt_nxt;
         dl_q    <= downloading;
         ack_q   <= bus.sd_ack;
         load_q  <= load_req;
         save_q  <= save_req;
         fmt_q   <= format_req;
         go_load <= idle_free & enabled & load_edge;
         go_save <= idle_free & enabled & save_edge & ~load_edge;
         go_fmt  <= idle_free & fmt_edge & ~load_edge & ~save_edge;
         if (downloading & ~dl_q)
            enabled <= 1'b0;
         else if (downloading & img_mounted & img_size_nz & ~img_readonly)
            enabled <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      lba_nxt   = lba;
      rd_nxt    = rd;
      wr_nxt    = wr;
      ld_nxt    = ld;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (go_load | go_save) begin
               lba_nxt   = 32'(slot) << LB;
               ld_nxt    = go_load;
               rd_nxt    = go_load;
               wr_nxt    = go_save;
               state_nxt = XFER;
            end else if (go_fmt) begin
               cnt_nxt   = '0;
               state_nxt = FMT;
            end
         end
         XFER: begin
            if (bus.sd_ack & ~ack_q) begin
               rd_nxt = 1'b0;
               wr_nxt = 1'b0;
            end else if (~bus.sd_ack & ack_q) begin
               if (lba[LB-1:0] == LB'(SECTORS - 1)) begin
                  state_nxt = IDLE;
                  ld_nxt    = 1'b0;
               end else begin
                  lba_nxt = lba + 32'd1;
                  rd_nxt  = ld;
                  wr_nxt  = ~ld;
               end
            end
         end
         FMT: begin
            cnt_nxt = cnt + AW'(1);
            if (cnt == FMT_LAST)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Port-B mux: format counter owns the port in FMT, otherwise the SD buffer drives it (loads only).
   always_comb begin
      bus.bram_addr = {lba[LB-1:0], bus.sd_buff_addr};
      bus.bram_din  = bus.sd_buff_dout;
      bus.bram_we   = bus.sd_buff_wr & bus.sd_ack & ld;
      if (state == FMT) begin
         bus.bram_addr = cnt;
         bus.bram_we   = 1'b1;
         case (cnt)
            AW'(0):  bus.bram_din = 16'h5548;
            AW'(1):  bus.bram_din = 16'h4D42;
            AW'(2):  bus.bram_din = 16'h8800;
            AW'(3):  bus.bram_din = 16'h8010;
            default: bus.bram_din = 16'h0000;
         endcase
      end
   end

   assign bus.sd_lba = lba;
   assign bus.sd_rd  = rd;
   assign bus.sd_wr  = wr;
   assign busy       = (state != IDLE);
   assign loading    = ld;
endmodule

// File: doc/brm_sync_ctrl.md
# brm_sync_ctrl

Sequencer and port-B arbiter for the PCE backup RAM (BRM). It owns the second port of the two byte-wide BRM banks and shares it between two users: the SD sector transfer that loads and saves a slot of the save file, and the format initializer that writes the HuBM header. It generates the sd_lba/sd_rd/sd_wr handshake for multi-sector load and save, and holds the core in reset while a load is in progress. It sits in the top level between hps_io and the BRM dual-port RAMs.

## Interface
Parameters:
- SECTORS, 16: sectors per save slot; power of two, 2..16. Each sector is 256 16-bit words.
- AW, log2(SECTORS)+8: BRM port-B word address width (derived; do not override).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- downloading  in  1  ROM download in progress.
- img_mounted  in  1  save-image mount strobe.
- img_readonly  in  1  mounted image is read-only.
- img_size_nz  in  1  mounted image size is non-zero.
- load_req  in  1  load-slot request; level input, acted on at its rising edge.
- save_req  in  1  save-slot request; level input, acted on at its rising edge.
- format_req  in  1  format request; level input, acted on at its rising edge.
- slot  in  2  save slot, sampled at start.
- sd_lba  out  32  sector address.
- sd_rd  out  1  SD read request.
- sd_wr  out  1  SD write request.
- sd_ack  in  1  SD transfer acknowledge.
- sd_buff_addr  in  8  word index within the sector.
- sd_buff_dout  in  16  word from SD (load).
- sd_buff_wr  in  1  SD buffer write strobe.
- bram_addr  out  AW  BRM port-B word address.
- bram_din  out  16  BRM port-B write data: [15:8] high bank, [7:0] low bank.
- bram_we  out  1  BRM port-B write enable, applied to both banks.
- enabled  out  1  a writable save image is mounted.
- busy  out  1  load, save or format in progress.
- loading  out  1  load in progress; ORed into the core reset.

## Operation
- Enable tracking:
  - The rising edge of downloading clears enabled.
  - While downloading=1, img_mounted & img_size_nz & ~img_readonly sets enabled.
- Request detection:
  - Each request is registered once; start occurs the cycle after the rising edge is seen.
  - Simultaneous rising edges: priority is load > save > format. Lower-priority edges in that cycle are dropped.
  - Edges seen while busy are dropped.
  - Load and save are accepted only if enabled=1. Format is accepted regardless of enabled.
- States:
  - IDLE: busy=0. On an accepted load/save: sd_lba ← {slot, 4'd0} (the low log2(SECTORS) bits are zero), loading ← is_load, sd_rd ← is_load, sd_wr ← ~is_load, go to XFER. On an accepted format: cnt ← 0, go to FMT.
  - XFER: rising sd_ack clears sd_rd and sd_wr. On falling sd_ack:
    - If sd_lba low bits = SECTORS-1: go to IDLE and clear loading.
    - Otherwise increment sd_lba by 1 and reassert sd_rd/sd_wr per loading.
  - FMT: bram_we=1 every cycle. addr=cnt. data = header[cnt] for cnt<4 (0x5548, 0x4D42, 0x8800, 0x8010), else 0. cnt increments each cycle. Exits to IDLE after the last word (see Configuration).
- Port-B mux:
  - In FMT: address and data come from the counter.
  - Otherwise: bram_addr = {sd_lba[log2(SECTORS)-1:0], sd_buff_addr}, bram_din = sd_buff_dout, bram_we = sd_buff_wr & sd_ack & loading.
  - The save path never writes the BRM.

## Timing
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, bram_we=0, busy=0, loading=0, enabled=0, state=IDLE. Reset mid-transfer or mid-format aborts immediately, with no further BRM writes.
- Request edge at cycle N: busy=1 and sd_rd/sd_wr valid at N+2.
- sd_lba is stable from request assertion until the falling sd_ack of that sector.
- The next request is asserted the cycle after the falling sd_ack.
- bram_we is combinational from sd_buff_wr and sd_ack (zero-latency pass-through).
- busy deasserts the cycle after the final falling sd_ack, or after the final format write.
- Format length: 4 cycles, or SECTORS·256 cycles with the clear feature enabled.
- sd_ack held high across a sector boundary is not a valid sequence. Behaviour is defined only for ack pulses separated by at least 1 low cycle.
- A mount strobe during XFER may set enabled but never affects the transfer.

## Configuration
- BRM_FORMAT_CLEAR_EN:
  - Defined: format writes header words 0–3, then zeros to every remaining word up to SECTORS·256-1, and exits after address SECTORS·256-1.
  - Undefined: format writes only words 0–3 (4 cycles) and exits after address 3; the rest of the BRM is untouched.

## Test plan
- Mount with downloading=1, img_size_nz=1, readonly=0 → enabled=1. Pulse save_req with slot=2 → sd_wr=1, sd_lba=0x20. Model 16 ack pulses → sd_lba steps 0x20..0x2F, busy drops after the 16th falling ack, bram_we never asserted.
- Load slot 1 with the model writing word w=lba·256+addr → loading=1 throughout. BRM contents after the load match the model. loading=0 one cycle after the last ack.
- Format without the macro → exactly 4 writes: 0:0x5548, 1:0x4D42, 2:0x8800, 3:0x8010. busy high for 4 cycles. With the macro → 4096 writes, words 4..4095 = 0.
- load_req and save_req rise in the same cycle → load performed, save dropped. save_req edge while busy → ignored. load_req with enabled=0 → no sd_rd.
- Reset asserted at sector 5 of a load → all outputs return to reset values the next cycle. Subsequent ack pulses produce no bram_we.
- Rising edge of downloading → enabled=0. A mount with img_readonly=1 → enabled stays 0.
